features_ram: RTL and testbench
===============================

Name: features_ram

Overview:
- Input-feature loader for the first convolution layer.
- After reset it fetches one 3-channel quantized image from DDR through a read-only burst client port of the round-robin arbiter and stores it in on-chip RAM.
- It then replays the image NUM_PASSES times as a ready/valid stream, one pixel per transfer, with all three channels in parallel. The conv layer consumes one pass per output-channel group.

Parameters:
- DATA_WIDTH, 64: DDR burst beat width; PIX_PER_BEAT = DATA_WIDTH/QUAN_BITS.
- ADDR_SIZE, 32: DDR byte-address width.
- LEN_WIDTH, 16: burst length field width, in beats.
- QUAN_BITS, 8: signed pixel width.
- IMG_H, 32: image height.
- IMG_W, 32: image width.
- BASE_ADDR, 0: DDR byte address of channel-0 plane.
- BURST_LEN, 64: beats per burst request.
- NUM_PASSES, 4: number of times the image is replayed.

Ports:
- s_clk  in  1  clock.
- s_rst  in  1  synchronous active-high reset.
- rd_burst_data  in  DATA_WIDTH  burst read beat.
- rd_burst_addr  out  ADDR_SIZE  burst start byte address.
- rd_burst_len  out  LEN_WIDTH  burst length in beats.
- rd_burst_req  out  1  burst request.
- rd_burst_valid  in  1  beat qualifier.
- rd_burst_finish  in  1  one-cycle pulse, burst complete.
- o_feature_data_ch0  out  QUAN_BITS  channel-0 pixel.
- o_feature_data_ch1  out  QUAN_BITS  channel-1 pixel.
- o_feature_data_ch2  out  QUAN_BITS  channel-2 pixel.
- o_f_data_valid  out  1  pixel triple valid.
- data_ready  in  1  consumer ready.
- load_d_once_done  out  1  one-cycle pulse at end of each pass.
- data_load_done  out  1  level, all passes complete.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state machine to S_IDLE; pass counter and pixel counter to 0. Reset mid-burst abandons the burst immediately and any further beats are ignored. Reset mid-stream drops valid the next cycle.
- DDR layout: three planes (ch0, ch1, ch2), contiguous from BASE_ADDR.
  - Each plane is IMG_H*IMG_W bytes, raster order (row-major).
  - PIX_PER_BEAT pixels per beat; byte 0 (bits [7:0]) is the lowest-address pixel.
  - Defaults give 128 beats per plane, 2 bursts per plane, 6 bursts total.
- States:
  - S_IDLE: go to S_REQ one cycle after reset release.
  - S_REQ: drive addr = BASE_ADDR + burst_idx*BURST_LEN*(DATA_WIDTH/8) and len = BURST_LEN, assert rd_burst_req. Go to S_RD.
  - S_RD: addr/len/req stay stable; req stays high until rd_burst_finish. Each rd_burst_valid beat is written to the RAM of the plane being loaded, at the next word address. On finish, req drops in the same edge. Go to S_REQ if bursts remain, else S_STREAM.
  - S_STREAM: replay pixels, described below.
  - S_DONE: terminal.
- Beats arriving without valid are ignored. Beats beyond BURST_LEN in one burst are dropped.
- Storage: three RAMs, one per channel, IMG_H*IMG_W/PIX_PER_BEAT words each. The pixel is selected by byte lane.
- S_STREAM output rules:
  - Pixel index p runs from 0 to IMG_H*IMG_W-1; output is chK = pixel p of plane K.
  - A transfer occurs on a cycle where o_f_data_valid && data_ready.
  - While valid is high and ready is low, data and valid hold stable.
  - RAM read latency is hidden by prefetch/skid: with ready held high, one transfer per cycle, no bubbles.
  - First valid appears within 3 cycles of entering S_STREAM.
- Pass end: after the transfer of the last pixel of a pass, load_d_once_done pulses 1 for exactly one cycle (the cycle after that transfer). The pass counter increments and p wraps to 0. The next pass begins with no bubble beyond 1 cycle.
- After the last transfer of pass NUM_PASSES-1:
  - load_d_once_done pulses.
  - data_load_done goes high in the same cycle and stays high until reset.
  - o_f_data_valid stays 0.
  - Go to S_DONE.
- data_ready is ignored outside S_STREAM.
- Outputs are registered; no combinational path from data_ready to o_f_data_valid.

Test Plan:
- Reset, then DDR model with byte at address a = a[7:0] -> exactly 6 requests: addr 0, 512, 1024, 1536, 2048, 2560, each len 64. req holds until each finish.
- Stream with data_ready=1 -> first triple (0x00, 0x00, 0x00). Pixel 9 = (0x09, 0x09, 0x09) (plane base 1024 -> low byte 0). 1024 consecutive transfers per pass with no gaps.
- Planes filled with constants 1/2/3 -> every triple is (1, 2, 3) signed. Byte 0xFF reads as -1.
- Random data_ready toggling -> data stable while valid&&!ready. No pixel skipped or duplicated; sequence equals raster order per pass.
- Full run -> load_d_once_done pulses exactly 4 times, each 1 cycle after transfer 1023 of its pass. data_load_done rises with the 4th pulse and stays high; no valid afterwards.
- Assert s_rst during the 3rd burst -> req=0, valid=0, done flags 0 next cycle. After release the fetch restarts from addr 0.

Source files
------------

// File: rtl/features_ram.sv
// features_ram: fetches a 3-plane quantized image from DDR over a burst read
//   port into three on-chip RAMs, then replays it NUM_PASSES times as a
//   ready/valid stream (one pixel, all three channels, per transfer).
// Latency: first pixel valid 2 cycles after streaming starts; 1 pixel/cycle.
// Backpressure: data_ready stalls the stream; a 2-entry prefetch (output reg +
//   skid reg) hides the 1-cycle RAM read so ready-high runs have no bubbles.
// Ports:
//   s_clk, s_rst          clock, synchronous active-high reset
//   rd_burst_*            read-only burst client (req/addr/len out, data/valid/finish in)
//   o_feature_data_ch0..2 pixel triple, qualified by o_f_data_valid, taken on data_ready
//   load_d_once_done      1-cycle pulse after the last transfer of each pass
//   data_load_done        level, high once all passes have been streamed
// Image size, lane count and burst length are assumed to be powers of two.
module features_ram #(
  parameter int          DATA_WIDTH = 64,
  parameter int          ADDR_SIZE  = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int          QUAN_BITS  = 8,
  parameter int          IMG_H      = 32,
  parameter int          IMG_W      = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          BURST_LEN  = 64,
  parameter int          NUM_PASSES = 4
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic [DATA_WIDTH-1:0] rd_burst_data,
  output logic [ADDR_SIZE-1:0]  rd_burst_addr,
  output logic [LEN_WIDTH-1:0]  rd_burst_len,
  output logic                  rd_burst_req,
  input  logic                  rd_burst_valid,
  input  logic                  rd_burst_finish,
  output logic [QUAN_BITS-1:0]  o_feature_data_ch0,
  output logic [QUAN_BITS-1:0]  o_feature_data_ch1,
  output logic [QUAN_BITS-1:0]  o_feature_data_ch2,
  output logic                  o_f_data_valid,
  input  logic                  data_ready,
  output logic                  load_d_once_done,
  output logic                  data_load_done
);

  localparam int PIX_PER_BEAT = DATA_WIDTH / QUAN_BITS;
  localparam int NPIX         = IMG_H * IMG_W;
  localparam int WORDS        = NPIX / PIX_PER_BEAT;
  localparam int NUM_BURSTS   = (3 * WORDS + BURST_LEN - 1) / BURST_LEN;
  localparam int BURST_BYTES  = BURST_LEN * (DATA_WIDTH / 8);
  localparam int PIX_W        = $clog2(NPIX);
  localparam int LANE_W       = $clog2(PIX_PER_BEAT);
  localparam int WA_W         = PIX_W - LANE_W;
  localparam int BI_W         = $clog2(NUM_BURSTS + 1);
  localparam int BC_W         = $clog2(BURST_LEN + 1);
  localparam int PASS_W       = $clog2(NUM_PASSES + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_STREAM, S_DONE} state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- load side
  logic [BI_W-1:0] burst_idx;
  logic [BC_W-1:0] beat_cnt;
  logic [WA_W-1:0] wr_word;
  logic [1:0]      wr_plane;
  logic            last_burst;
  logic            beat_ok;

  assign last_burst = (burst_idx == BI_W'(NUM_BURSTS - 1));
  // Beats beyond BURST_LEN, or past the third plane, are dropped.
  assign beat_ok = (state_q == S_RD) && rd_burst_valid &&
                   (beat_cnt < BC_W'(BURST_LEN)) && (wr_plane != 2'd3);

  // -------------------------------------------------------------- stream side
  logic [PIX_W-1:0]  iss_pix;      // next pixel to read from RAM
  logic [PASS_W-1:0] iss_pass;
  logic              iss_done;
  logic [PIX_W-1:0]  xfer_pix;     // next pixel to hand to the consumer
  logic [PASS_W-1:0] xfer_pass;
  logic              rd_en;
  logic              rd_pend;      // RAM output holds a pixel this cycle
  logic [LANE_W-1:0] rd_lane_q;
  logic [WA_W-1:0]   rd_word;
  logic              out_vld, skid_vld, xfer, last_xfer;
  logic [1:0]        occ;
  logic [2:0][QUAN_BITS-1:0]  out_dat, skid_dat, pix_rd;
  logic [2:0][DATA_WIDTH-1:0] ram_q;

  assign rd_word   = iss_pix[PIX_W-1:LANE_W];
  assign xfer      = (state_q == S_STREAM) && out_vld && data_ready;
  assign last_xfer = xfer && (xfer_pix == PIX_W'(NPIX - 1)) &&
                     (xfer_pass == PASS_W'(NUM_PASSES - 1));
  // Items in flight (output, skid, RAM read). Issue a read only if, after this
  // cycle's transfer, there is still room for it in output+skid.
  assign occ   = 2'(out_vld) + 2'(skid_vld) + 2'(rd_pend);
  assign rd_en = (state_q == S_STREAM) && !iss_done && ((occ - 2'(xfer)) < 2'd2);

  // ------------------------------------------------------------------ RAMs
  for (genvar k = 0; k < 3; k++) begin : g_plane
    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [DATA_WIDTH-1:0] q;
    always_ff @(posedge s_clk) begin
      if (beat_ok && (wr_plane == 2'(k))) mem[wr_word] <= rd_burst_data;
      if (rd_en) q <= mem[rd_word];
    end
    assign ram_q[k] = q;
  end

  // Byte-lane select of the word read last cycle.
  always_comb begin
    pix_rd = '0;
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < PIX_PER_BEAT; l++) begin
        if (rd_lane_q == LANE_W'(l)) pix_rd[k] = ram_q[k][l*QUAN_BITS +: QUAN_BITS];
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge s_clk) begin
    if (s_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_REQ;
      S_REQ:    state_d = S_RD;
      S_RD:     if (rd_burst_finish) state_d = last_burst ? S_STREAM : S_REQ;
      S_STREAM: if (last_xfer) state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- burst datapath
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
      burst_idx     <= '0;
      beat_cnt      <= '0;
      wr_word       <= '0;
      wr_plane      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rd_burst_addr <= ADDR_SIZE'(BASE_ADDR);
          rd_burst_len  <= LEN_WIDTH'(BURST_LEN);
        end
        S_REQ: begin
          rd_burst_req <= 1'b1;
          beat_cnt     <= '0;
        end
        S_RD: begin
          if (beat_ok) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (wr_word == WA_W'(WORDS - 1)) begin
              wr_word  <= '0;
              wr_plane <= wr_plane + 1'b1;
            end else begin
              wr_word <= wr_word + 1'b1;
            end
          end
          if (rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            burst_idx    <= burst_idx + 1'b1;
            if (!last_burst) rd_burst_addr <= rd_burst_addr + ADDR_SIZE'(BURST_BYTES);
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------ stream datapath
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      iss_pix          <= '0;
      iss_pass         <= '0;
      iss_done         <= 1'b0;
      xfer_pix         <= '0;
      xfer_pass        <= '0;
      rd_pend          <= 1'b0;
      rd_lane_q        <= '0;
      out_vld          <= 1'b0;
      out_dat          <= '0;
      skid_vld         <= 1'b0;
      skid_dat         <= '0;
      load_d_once_done <= 1'b0;
      data_load_done   <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) begin
        rd_lane_q <= iss_pix[LANE_W-1:0];
        if (iss_pix == PIX_W'(NPIX - 1)) begin
          iss_pix <= '0;
          if (iss_pass == PASS_W'(NUM_PASSES - 1)) iss_done <= 1'b1;
          else                                     iss_pass <= iss_pass + 1'b1;
        end else begin
          iss_pix <= iss_pix + 1'b1;
        end
      end

      // Output register refills from skid first (older), then from the RAM.
      if (xfer || !out_vld) begin
        if (skid_vld) begin
          out_dat  <= skid_dat;
          out_vld  <= 1'b1;
          skid_vld <= rd_pend;
          if (rd_pend) skid_dat <= pix_rd;
        end else if (rd_pend) begin
          out_dat <= pix_rd;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_dat <= pix_rd;
        skid_vld <= 1'b1;
      end

      load_d_once_done <= 1'b0;
      if (xfer) begin
        if (xfer_pix == PIX_W'(NPIX - 1)) begin
          xfer_pix         <= '0;
          load_d_once_done <= 1'b1;
          if (xfer_pass == PASS_W'(NUM_PASSES - 1)) data_load_done <= 1'b1;
          else                                      xfer_pass <= xfer_pass + 1'b1;
        end else begin
          xfer_pix <= xfer_pix + 1'b1;
        end
      end
    end
  end

  assign o_f_data_valid     = out_vld;
  assign o_feature_data_ch0 = out_dat[0];
  assign o_feature_data_ch1 = out_dat[1];
  assign o_feature_data_ch2 = out_dat[2];

endmodule

// File: tb/tb_features_ram.sv
module tb_features_ram;
  localparam int NPIX = 1024;
  localparam int NB   = 6;
  localparam int NP   = 4;
  localparam int BLEN = 64;

  logic        s_clk = 1'b0;
  logic        s_rst = 1'b1;
  logic [63:0] rd_burst_data = '0;
  logic [31:0] rd_burst_addr;
  logic [15:0] rd_burst_len;
  logic        rd_burst_req;
  logic        rd_burst_valid = 1'b0;
  logic        rd_burst_finish = 1'b0;
  logic [7:0]  ch0, ch1, ch2;
  logic        o_f_data_valid;
  logic        data_ready = 1'b0;
  logic        load_d_once_done, data_load_done;

  features_ram dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .rd_burst_data(rd_burst_data), .rd_burst_addr(rd_burst_addr),
    .rd_burst_len(rd_burst_len), .rd_burst_req(rd_burst_req),
    .rd_burst_valid(rd_burst_valid), .rd_burst_finish(rd_burst_finish),
    .o_feature_data_ch0(ch0), .o_feature_data_ch1(ch1), .o_feature_data_ch2(ch2),
    .o_f_data_valid(o_f_data_valid), .data_ready(data_ready),
    .load_d_once_done(load_d_once_done), .data_load_done(data_load_done)
  );

  always #5 s_clk = ~s_clk;
  int cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------- DDR image
  logic [7:0] mem [3*NPIX];
  task automatic fill(input int mode);
    for (int a = 0; a < 3*NPIX; a++) begin
      case (mode)
        0:       mem[a] = 8'(a);
        1:       mem[a] = 8'(a / NPIX + 1);
        default: mem[a] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // -------------------------------------------------- burst responder
  int          addr_q[$];
  int          len_q[$];
  int          cur_beats = 0;
  int          fin_cyc = 0;
  int          req_err = 0;
  bit          extra_beats = 1'b0;

  initial begin
    int ph = 0;
    int beat = 0;
    int blen = 0;
    logic [31:0] baddr = '0;
    forever begin
      @(posedge s_clk); #1;
      rd_burst_valid  = 1'b0;
      rd_burst_finish = 1'b0;
      rd_burst_data   = {$urandom, $urandom};   // garbage on non-valid cycles
      if (s_rst) begin
        ph = 0;
        continue;
      end
      case (ph)
        0: if (rd_burst_req) begin
             baddr = rd_burst_addr;
             blen  = int'(rd_burst_len);
             addr_q.push_back(int'(baddr));
             len_q.push_back(blen);
             beat = 0;
             cur_beats = 0;
             ph = 1;
           end
        1: begin
             if (!rd_burst_req || rd_burst_addr != baddr) req_err++;
             if ($urandom_range(0, 3) != 0) begin
               rd_burst_valid = 1'b1;
               for (int b = 0; b < 8; b++)
                 rd_burst_data[8*b +: 8] = (beat < blen) ? mem[int'(baddr) + 8*beat + b] : 8'hEE;
               beat++;
               cur_beats = beat;
               if (beat >= blen + (extra_beats ? 2 : 0)) ph = 2;
             end
           end
        2: begin
             if (!rd_burst_req) req_err++;
             rd_burst_finish = 1'b1;
             fin_cyc = cyc;
             ph = 3;
           end
        default: begin
             if (rd_burst_req) req_err++;   // must drop on the finish edge
             ph = 0;
           end
      endcase
    end
  end

  // ------------------------------------------------- stream reference model
  int mp, mpass, pulses, xfers, bubbles, first_vcyc, dld_drop, post_valid;
  bit pulse_exp, prev_hold, dld_seen;
  logic [23:0] prev_dat, cur;
  logic [7:0]  cap0 [NPIX];
  logic [7:0]  cap1 [NPIX];
  logic [7:0]  cap2 [NPIX];

  always @(negedge s_clk) begin
    if (s_rst) begin
      mp = 0; mpass = 0; pulses = 0; xfers = 0; bubbles = 0;
      first_vcyc = -1; dld_drop = 0; post_valid = 0;
      pulse_exp = 0; prev_hold = 0; dld_seen = 0;
    end else begin
      if (load_d_once_done || pulse_exp)
        chk("once_done_timing", longint'(load_d_once_done), longint'(pulse_exp));
      if (load_d_once_done) pulses++;
      pulse_exp = 0;
      if (dld_seen && !data_load_done) dld_drop++;
      if (data_load_done && !dld_seen) begin
        dld_seen = 1;
        chk("done_rises_with_last_pulse", {load_d_once_done, 8'(pulses)}, {1'b1, 8'(NP)});
      end
      if (dld_seen && o_f_data_valid) post_valid++;

      cur = {ch2, ch1, ch0};
      if (o_f_data_valid && first_vcyc < 0) first_vcyc = cyc;
      if (prev_hold) chk("hold_stable", {o_f_data_valid, cur}, {1'b1, prev_dat});
      if (o_f_data_valid && data_ready) begin
        chk($sformatf("pix_pass%0d_p%0d", mpass, mp), cur,
            {mem[2*NPIX + mp], mem[NPIX + mp], mem[mp]});
        if (mpass == 0) begin
          cap0[mp] = ch0; cap1[mp] = ch1; cap2[mp] = ch2;
        end
        xfers++;
        if (mp == NPIX - 1) begin
          mp = 0; mpass++; pulse_exp = 1;
        end else begin
          mp++;
        end
      end else if (data_ready && mp != 0) begin
        bubbles++;
      end
      prev_hold = o_f_data_valid && !data_ready;
      prev_dat  = cur;
    end
  end

  // ------------------------------------------------------------ tables
  typedef struct { int mode; bit rnd_rdy; bit extra; bit mid_rst; } scen_t;
  typedef struct { int mode; int p; int e0; int e1; int e2; } probe_t;
  scen_t  scen   [4];
  probe_t probes [8];

  task automatic run_scen(input scen_t s);
    int n;
    fill(s.mode);
    extra_beats = s.extra;
    s_rst = 1'b1;
    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    chk("rst_bus", {rd_burst_req, rd_burst_addr, rd_burst_len}, 0);
    chk("rst_stream", {o_f_data_valid, ch0, ch1, ch2, load_d_once_done, data_load_done}, 0);
    addr_q.delete(); len_q.delete(); req_err = 0;
    @(posedge s_clk); #1;
    s_rst = 1'b0;

    if (s.mid_rst) begin
      data_ready = 1'b1;
      n = 0;
      while (!(addr_q.size() == 3 && cur_beats >= 10) && n < 3000) begin
        @(posedge s_clk); #1;
        n++;
      end
      chk("third_burst_reached", longint'(n < 3000), 1);
      s_rst = 1'b1;
      @(posedge s_clk);
      @(negedge s_clk);
      chk("midrst_outputs", {rd_burst_req, o_f_data_valid, load_d_once_done, data_load_done}, 0);
      addr_q.delete(); len_q.delete(); req_err = 0;
      @(posedge s_clk); #1;
      s_rst = 1'b0;
    end

    n = 0;
    while (!data_load_done && n < 30000) begin
      @(posedge s_clk); #1;
      data_ready = s.rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk("load_done_in_budget", longint'(n < 30000), 1);
    repeat (20) begin
      @(posedge s_clk); #1;
      data_ready = 1'($urandom_range(0, 1));
    end
    @(negedge s_clk);

    chk("req_count", addr_q.size(), NB);
    for (int i = 0; i < NB && i < addr_q.size(); i++) begin
      chk($sformatf("req_addr_%0d", i), addr_q[i], i * BLEN * 8);
      chk($sformatf("req_len_%0d", i), len_q[i], BLEN);
    end
    chk("req_held_until_finish", req_err, 0);
    chk("pass_pulses", pulses, NP);
    chk("transfers", xfers, NP * NPIX);
    chk("valid_after_done", post_valid, 0);
    chk("done_level_held", dld_drop, 0);
    chk("done_level_now", longint'(data_load_done), 1);
    chk("first_valid_latency_ok",
        longint'(first_vcyc - fin_cyc >= 1 && first_vcyc - fin_cyc <= 4), 1);
    if (!s.rnd_rdy) chk("no_bubbles", bubbles, 0);
    for (int i = 0; i < 8; i++) begin
      if (probes[i].mode == s.mode) begin
        chk($sformatf("probe_m%0d_p%0d_ch0", s.mode, probes[i].p),
            int'($signed(cap0[probes[i].p])), probes[i].e0);
        chk($sformatf("probe_m%0d_p%0d_ch1", s.mode, probes[i].p),
            int'($signed(cap1[probes[i].p])), probes[i].e1);
        chk($sformatf("probe_m%0d_p%0d_ch2", s.mode, probes[i].p),
            int'($signed(cap2[probes[i].p])), probes[i].e2);
      end
    end
  endtask

  initial begin
    // mode 0: byte = address[7:0]; mode 1: planes 1/2/3; mode 2: random bytes
    scen[0] = '{0, 1'b0, 1'b1, 1'b0};
    scen[1] = '{1, 1'b0, 1'b0, 1'b0};
    scen[2] = '{2, 1'b1, 1'b0, 1'b0};
    scen[3] = '{0, 1'b1, 1'b0, 1'b1};
    probes[0] = '{0, 0,    0,  0,  0};
    probes[1] = '{0, 9,    9,  9,  9};
    probes[2] = '{0, 255, -1, -1, -1};
    probes[3] = '{0, 256,  0,  0,  0};
    probes[4] = '{0, 520,  8,  8,  8};
    probes[5] = '{0, 1023, -1, -1, -1};
    probes[6] = '{1, 0,    1,  2,  3};
    probes[7] = '{1, 777,  1,  2,  3};
    for (int i = 0; i < 4; i++) run_scen(scen[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
